// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions for the iterative multiplier and the
// control unit that stalls on it.
package cpu_pkg;

    localparam int MUL_W       = 32;
    // Cycles from an accepted start request to the done pulse.
    localparam int MUL_LATENCY = MUL_W + 2;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_FIX  = 2'd2,
        MUL_DONE = 2'd3
    } mul_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier. Signed operands are reduced to magnitudes
// at capture, multiplied unsigned over W cycles, then the sign is restored.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift-add step per cycle, W steps
// FIX   | apply sign, load product
// DONE  | done pulse; may accept the next start directly
module seq_multiplier
    import cpu_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int CW = $clog2(W);

    mul_state_e       state_q,  state_d;
    logic [2*W-1:0]   acc_q,    acc_d;
    logic [W-1:0]     mcand_q,  mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic             neg_q,    neg_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [2*W-1:0]   prod_q,   prod_d;

    logic [W:0]       sum;
    logic             accept;

    // Magnitude of an operand; the most negative value maps to 2^(W-1),
    // which still fits in W unsigned bits.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic s);
        return (s && v[W-1]) ? ((~v) + W'(1)) : v;
    endfunction

    assign sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, (mplier_q[0] ? mcand_q : {W{1'b0}})};
    assign accept = start && ((state_q == MUL_IDLE) || (state_q == MUL_DONE));

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;

        case (state_q)
            MUL_IDLE: state_d = MUL_IDLE;
            MUL_RUN: begin
                acc_d    = {sum, acc_q[W-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = MUL_FIX;
                end
            end
            MUL_FIX: begin
                prod_d  = neg_q ? ((~acc_q) + (2*W)'(1)) : acc_q;
                state_d = MUL_DONE;
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase

        // Start is honoured from IDLE and from DONE, so back-to-back
        // requests lose no cycle.
        if (accept) begin
            mcand_d  = magnitude(a_in, signed_op);
            mplier_d = magnitude(b_in, signed_op);
            neg_d    = signed_op && (a_in[W-1] ^ b_in[W-1]);
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL_RUN;
        end
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= MUL_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

    assign busy    = (state_q == MUL_RUN) || (state_q == MUL_FIX);
    assign done    = (state_q == MUL_DONE);
    assign product = prod_q;

endmodule
